// File: rtl/counter4_extend_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | counter4_extend_timer: extends a 4-bit counter into a wide timebase,     |
// | runs a START/TARGET interval timer on it and flags upstream faults.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module counter4_extend_timer #(
  parameter int HI_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  ASYNCRESET,
  input  logic [3:0]            I,
  input  logic                  CIN,
  input  logic                  START,
  input  logic                  ABORT,
  input  logic [HI_WIDTH+3:0]   TARGET,
  output logic [HI_WIDTH+3:0]   O,
  output logic [HI_WIDTH+3:0]   ELAPSED,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  MATCH,
  output logic                  ERR
);

  localparam int W = HI_WIDTH + 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                state;
  logic [HI_WIDTH-1:0]   hi;
  logic [W-1:0]          start_val;
  logic [W-1:0]          target_val;
  logic [W-1:0]          elapsed;
  logic                  match;
  logic                  err;
  logic [3:0]            prev_i;
  logic                  valid;

  logic [W-1:0]          diff;
  logic [3:0]            next_i;
  logic                  count_fault;

  assign O       = {hi, I};
  // Modular subtraction lets an interval straddle the timebase wrap.
  assign diff    = O - start_val;
  assign next_i  = prev_i + 4'd1;
  assign count_fault = (valid && (I != next_i)) || (CIN != (I == 4'hF));

  assign ELAPSED = elapsed;
  assign BUSY    = (state == ST_RUN);
  assign DONE    = (state == ST_DONE);
  assign MATCH   = match;
  assign ERR     = err;

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      hi         <= '0;
      elapsed    <= '0;
      match      <= 1'b0;
      err        <= 1'b0;
      state      <= ST_IDLE;
      start_val  <= '0;
      target_val <= '0;
      prev_i     <= 4'd0;
      valid      <= 1'b0;
    end else begin
      if (CIN) begin
        hi <= hi + 1'b1;
      end

      prev_i <= I;
      valid  <= 1'b1;
      if (count_fault) begin
        err <= 1'b1;
      end

      match <= 1'b0;
      if (ABORT) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (START) begin
              start_val  <= O;
              target_val <= TARGET;
              elapsed    <= '0;
              if (TARGET == '0) begin
                state <= ST_DONE;
                match <= 1'b1;
              end else begin
                state <= ST_RUN;
              end
            end
          end
          ST_RUN: begin
            elapsed <= diff;
            if (diff == target_val) begin
              state <= ST_DONE;
              match <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/counter4_extend_timer.md
Name: counter4_extend_timer

Overview:
- Sits directly downstream of the 4-bit free-running counter with carry-out. Consumes its count O and carry COUT.
- Extends the count to a wide timebase by counting carries into a high-order register.
- Runs a START/TARGET interval timer against that timebase and pulses MATCH when the programmed interval elapses.
- Monitors the upstream counter and raises a sticky ERR flag if it misbehaves.

Parameters:
- HI_WIDTH, 8, width of the carry-driven high-order count. Full timebase width W = HI_WIDTH+4.

Ports:
- CLK  in  1  rising-edge clock, shared with the upstream counter
- ASYNCRESET  in  1  asynchronous, active-high reset
- I  in  4  upstream counter value (its O)
- CIN  in  1  upstream carry (its COUT); high exactly when I==4'hF
- START  in  1  arm the timer (level, sampled at edge)
- ABORT  in  1  cancel the timer (sampled at edge)
- TARGET  in  W  interval length in counts, latched at START
- O  out  W  timebase {HI, I}, combinational concatenation
- ELAPSED  out  W  registered counts since START
- BUSY  out  1  high in RUN
- DONE  out  1  high in DONE
- MATCH  out  1  one-cycle registered pulse on interval completion
- ERR  out  1  sticky upstream-counter fault flag

Behaviour:
- Reset values (asynchronous, immediate on ASYNCRESET=1):
  - HI=0, ELAPSED=0, MATCH=0, ERR=0
  - state=IDLE, S=0, T=0, prev_I=0, valid=0
  - O therefore reads {0, I}
- Reset mid-operation: abandons any interval; no MATCH is generated.
- Timebase: at each edge, if CIN=1 then HI<=HI+1, wrapping mod 2^HI_WIDTH; otherwise HI holds. O={HI,I} rolls from 0x0FF to 0x100 on the edge where I wraps 15->0.
- FSM states: IDLE, RUN, DONE. BUSY=(state==RUN); DONE=(state==DONE). MATCH defaults to 0 every edge unless set below.
- Priority at each edge: ABORT > START > match.
- ABORT=1 in any state -> IDLE; MATCH stays 0; ELAPSED holds.
- IDLE or DONE with START=1:
  - S<=O (value before the edge), T<=TARGET, ELAPSED<=0.
  - If TARGET==0: go to DONE and set MATCH<=1.
  - Otherwise: go to RUN.
- RUN:
  - E=(O-S) mod 2^W; ELAPSED<=E.
  - If E==T: go to DONE and set MATCH<=1. Otherwise stay in RUN.
  - START is ignored while in RUN.
- DONE: holds; ELAPSED holds the final value. Leaves only on START (restart) or ABORT.
- Latency: MATCH is high during the cycle immediately after the edge at which E==T was sampled.
- Wrap-around: the subtraction is modular, so an interval spanning the O wrap from 2^W-1 to 0 completes correctly. The maximum TARGET is 2^W-1.
- Monitor, evaluated at every edge:
  - prev_I<=I; valid<=1.
  - ERR<=1 if valid && I != prev_I+1 (mod 16).
  - ERR<=1 if CIN != (I==4'hF).
  - ERR is cleared only by ASYNCRESET.
- Simultaneous START and ABORT: ABORT wins; the timer goes to IDLE.
- Changes to TARGET during RUN have no effect.

Test Plan:
- Reset, then drive a legal count (I=0,1,2,... with CIN on I==15) -> O=0x00F then 0x010 after the 15->0 edge. After 256 wraps O returns to 0x000. ERR stays 0 throughout.
- START=1 sampled while O=0x003, TARGET=5 -> BUSY for 5 cycles. At the edge with O=0x008, ELAPSED=5; then DONE=1 and MATCH=1 for exactly one cycle while O=0x009.
- START sampled at O=0xFFE, TARGET=4 -> MATCH at the edge where O=0x002 (wrap crossed), ELAPSED=4.
- START with TARGET=0 -> DONE=1 and MATCH=1 in the next cycle, ELAPSED=0. A second START from DONE with TARGET=2 restarts the timer and MATCH fires 2 counts later.
- START with TARGET=10, ABORT after 3 cycles -> IDLE, BUSY=0, ELAPSED=3, MATCH never asserts. Assert ASYNCRESET mid-RUN -> all outputs 0 immediately.
- Drive I 5->7 (skip), or CIN=1 with I=4'h7 -> ERR=1 after that edge. ERR stays 1 through later legal counting until ASYNCRESET.
